// File: rtl/vga_burst_reader.sv
// vga_burst_reader: Avalon-MM burst-read host that streams the framebuffer
// from SDRAM into a show-ahead pixel FIFO for the VGA output path.
//
// state | meaning
// IDLE  | apply a pending restart, else start a burst once a full burst fits
// REQ   | avm_read held with a stable address until the agent accepts it
// DATA  | count returned beats; store them unless a restart is pending
module vga_burst_reader #(
  parameter int unsigned HDISP        = 800,
  parameter int unsigned VDISP        = 480,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int unsigned BURSTSIZE    = 16,
  parameter int unsigned FIFO_DEPTH   = 256,
  parameter int unsigned BURSTCOUNT_W = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [31:0]                   avm_address,
  output logic                          avm_read,
  output logic [BURSTCOUNT_W-1:0]       avm_burstcount,
  output logic [3:0]                    avm_byteenable,
  output logic                          avm_write,
  output logic [31:0]                   avm_writedata,
  input  logic                          avm_waitrequest,
  input  logic [31:0]                   avm_readdata,
  input  logic                          avm_readdatavalid,
  input  logic                          frame_start,
  input  logic                          pix_rd,
  output logic [31:0]                   pix_data,
  output logic                          pix_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W       = PTR_W + 1;
  localparam int unsigned BEAT_W      = $clog2(BURSTSIZE) + 1;
  localparam int unsigned FRAME_WORDS = HDISP * VDISP;

  localparam logic [31:0]       BURST_BYTES   = 32'(4 * BURSTSIZE);
  localparam logic [31:0]       BURST_WORDS   = 32'(BURSTSIZE);
  localparam logic [31:0]       LAST_WORD_CNT = 32'(FRAME_WORDS - BURSTSIZE);
  localparam logic [LVL_W-1:0]  FILL_LIMIT    = LVL_W'(FIFO_DEPTH - BURSTSIZE);
  localparam logic [LVL_W-1:0]  FULL_LEVEL    = LVL_W'(FIFO_DEPTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT     = BEAT_W'(BURSTSIZE - 1);

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  state_t            state_q, state_d;
  logic              read_q, read_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       word_cnt_q, word_cnt_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              restart_q, restart_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic              push;
  logic              pop;
  logic              flush;
  logic              discard;

  // Write-side constants never change, reset included.
  assign avm_burstcount = BURSTCOUNT_W'(BURSTSIZE);
  assign avm_byteenable = 4'hF;
  assign avm_write      = 1'b0;
  assign avm_writedata  = 32'h0;

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign fifo_level  = level_q;
  assign pix_empty   = (level_q == '0);
  // Head word is shown only while valid, so an empty FIFO reads as zero.
  assign pix_data    = pix_empty ? 32'h0 : fifo_mem[rd_ptr_q];

  // A frame_start pulse landing on a beat discards that beat as well.
  assign discard = restart_q | frame_start;

  // Burst sequencing: next state, request, address and beat bookkeeping.
  always_comb begin
    state_d    = state_q;
    read_d     = read_q;
    addr_d     = addr_q;
    word_cnt_d = word_cnt_q;
    beat_cnt_d = beat_cnt_q;
    restart_d  = restart_q;
    push       = 1'b0;
    flush      = 1'b0;
    case (state_q)
      IDLE: begin
        if (restart_q) begin
          flush      = 1'b1;
          addr_d     = BASE_ADDR;
          word_cnt_d = '0;
          restart_d  = 1'b0;
        end else if (level_q <= FILL_LIMIT) begin
          read_d  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (!avm_waitrequest) begin
          read_d  = 1'b0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (avm_readdatavalid) begin
          push = !discard;
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = IDLE;
            // A pending restart reloads the address in IDLE instead.
            if (!discard) begin
              if (word_cnt_q == LAST_WORD_CNT) begin
                addr_d     = BASE_ADDR;
                word_cnt_d = '0;
              end else begin
                addr_d     = addr_q + BURST_BYTES;
                word_cnt_d = word_cnt_q + BURST_WORDS;
              end
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (frame_start) restart_d = 1'b1;
  end

  // FIFO pointer and level update; level is tracked explicitly.
  always_comb begin
    pop      = pix_rd && (level_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
    end
  end

  // Register all control state; async reset returns to the idle, empty state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      read_q     <= 1'b0;
      addr_q     <= BASE_ADDR;
      word_cnt_q <= '0;
      beat_cnt_q <= '0;
      restart_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      read_q     <= read_d;
      addr_q     <= addr_d;
      word_cnt_q <= word_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      restart_q  <= restart_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  // FIFO storage write port; contents need no reset since level gates reads.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= avm_readdata;
  end

  // The IDLE space check must make a push into a full FIFO impossible.
  assert property (@(posedge clk) disable iff (rst) !(push && level_q == FULL_LEVEL));

endmodule
